// File: rtl/dap_seq_engine.sv
// SWD/JTAG/SWJ bit-sequence engine: a command FIFO feeds an LSB-first shifter that
// launches bits on sclk_pulse, samples on sclk_delay_pulse and returns a response.
module dap_seq_engine #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sclk,
  input  logic              resetn,
  input  logic              sclk_out,
  input  logic              sclk_pulse,
  input  logic              sclk_delay_pulse,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_flag,
  output logic [DATA_W-1:0] rsp_data,
  output logic              swclk_o,
  output logic              swdio_t,
  output logic              swdio_o,
  input  logic              swdio_i,
  input  logic              tdo_i,
  output logic              tdi_o,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [15:0]       fifo_cmd  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              push, pop, fifo_empty;

  logic [15:0]       head_cmd;
  logic [3:0]        head_op;
  logic              head_ok;
  logic [CNT_W-1:0]  head_bits;

  logic [15:0]       cur_cmd;
  logic [3:0]        op;
  logic              op_ok, cap_en, drive_swdio, rx_pin;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;
  logic [IDX_W-1:0]  rx_idx;
  logic              clk_en;

  assign fifo_empty = (fifo_cnt == '0);
  assign cmd_ready  = (fifo_cnt != (PTR_W+1)'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && !fifo_empty && !rsp_valid;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign swclk_o    = clk_en & ~sclk_out;

  always_ff @(posedge sclk) begin
    if (push) begin
      fifo_cmd[wr_ptr]  <= cmd;
      fifo_data[wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Count 0 and anything wider than the shifter both mean a full DATA_W transfer.
  always_comb begin
    head_cmd = fifo_cmd[rd_ptr];
    head_op  = head_cmd[15:12];
    head_ok  = (head_op == 4'd1) || (head_op == 4'd2) || (head_op == 4'd3);
    if (head_cmd[7:0] == 8'd0 || 32'(head_cmd[7:0]) > DATA_W)
      head_bits = CNT_W'(DATA_W);
    else
      head_bits = CNT_W'(head_cmd[7:0]);
  end

  always_comb begin
    op          = cur_cmd[15:12];
    op_ok       = (op == 4'd1) || (op == 4'd2) || (op == 4'd3);
    cap_en      = ((op == 4'd2) && cur_cmd[8]) || ((op == 4'd3) && cur_cmd[9]);
    drive_swdio = (op == 4'd1) || ((op == 4'd2) && !cur_cmd[8]);
    rx_pin      = (op == 4'd3) ? tdo_i : swdio_i;
  end

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (tx_cnt == '0 && rx_cnt == '0 && !clk_en) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A sample is only taken once its bit has launched (rx_cnt ahead of tx_cnt), and
  // it is evaluated on the pre-launch counters so a coincident strobe samples first.
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      cur_cmd   <= '0;
      shift_reg <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      clk_en    <= 1'b0;
      swdio_t   <= 1'b1;
      swdio_o   <= 1'b0;
      tdi_o     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_flag  <= '0;
      rsp_data  <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur_cmd   <= head_cmd;
            shift_reg <= fifo_data[rd_ptr];
            rx_idx    <= '0;
            rsp_data  <= '0;
            clk_en    <= 1'b0;
            tx_cnt    <= head_ok ? head_bits : '0;
            rx_cnt    <= head_ok ? head_bits : '0;
          end
        end
        LOAD: begin
          case (op)
            4'd1: swdio_t <= 1'b0;
            4'd2: swdio_t <= cur_cmd[8];
            4'd3: begin
              swdio_t <= 1'b0;
              swdio_o <= cur_cmd[10];
            end
            default: swdio_t <= swdio_t;
          endcase
        end
        SHIFT: begin
          if (sclk_delay_pulse && rx_cnt > tx_cnt) begin
            if (cap_en) rsp_data[rx_idx] <= rx_pin;
            rx_idx <= rx_idx + IDX_W'(1);
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
          if (sclk_pulse) begin
            if (tx_cnt != '0) begin
              clk_en    <= 1'b1;
              tx_cnt    <= tx_cnt - CNT_W'(1);
              shift_reg <= shift_reg >> 1;
              if (op == 4'd3)       tdi_o   <= shift_reg[0];
              else if (drive_swdio) swdio_o <= shift_reg[0];
            end else begin
              clk_en <= 1'b0;
            end
          end
        end
        DONE: begin
          rsp_valid <= 1'b1;
          rsp_flag  <= op_ok ? cur_cmd : {cur_cmd[15:12], 1'b1, cur_cmd[10:0]};
        end
        default: ;
      endcase
    end
  end

endmodule
